// File: rtl/fpu_issue_pkg.sv
// Shared opcode constants, sequencer states and instruction-class decode for the FPU issue sequencer.
// Every other file in the block imports this package.
package fpu_issue_pkg;

   localparam int INSTR_W = 32;
   localparam int CNT_W   = 16;

   localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
   localparam logic [6:0] OPC_FMADD  = 7'b1000011;
   localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
   localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
   localparam logic [6:0] OPC_FNMADD = 7'b1001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WB1     = 3'd2,
      ST_WB2     = 3'd3,
      ST_FP_WAIT = 3'd4,
      ST_HALT    = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      CLS_INT = 2'd0,
      CLS_CSR = 2'd1,
      CLS_FP  = 2'd2
   } iclass_e;

   function automatic iclass_e decode_class(input logic [6:0] opcode);
      iclass_e cls;
      case (opcode)
         OPC_OP_FP, OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: cls = CLS_FP;
         OPC_SYSTEM: cls = CLS_CSR;
         default:    cls = CLS_INT;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/fpu_issue_seq_if.sv
// Host push handshake, decoder/FPU handshake and status bundle of the issue sequencer.
// The slave modport is the sequencer side; the master modport is the host/decoder side.
interface fpu_issue_seq_if;
   import fpu_issue_pkg::*;

   logic               host_valid;
   logic [INSTR_W-1:0] host_instr;
   logic               host_ready;
   logic               start;
   logic               resume;
   logic [INSTR_W-1:0] Instruction;
   logic               Activation_Signal;
   logic               fpu_active;
   logic               fpu_complete;
   logic               halt_req;
   logic               illegal_config;
   logic               busy;
   logic               halted;
   logic               err_timeout;
   logic               err_illegal;
   logic [CNT_W-1:0]   issued_count;

   modport slave (
      input  host_valid, host_instr, start, resume, fpu_complete, halt_req, illegal_config,
      output host_ready, Instruction, Activation_Signal, fpu_active, busy, halted,
             err_timeout, err_illegal, issued_count
   );

   modport master (
      output host_valid, host_instr, start, resume, fpu_complete, halt_req, illegal_config,
      input  host_ready, Instruction, Activation_Signal, fpu_active, busy, halted,
             err_timeout, err_illegal, issued_count
   );

endinterface

// File: rtl/fpu_issue_fifo.sv
// Instruction buffer, DEPTH x 32; head word visible combinationally, pop/push take effect at the edge.
// Push is ignored when full, pop ignored when empty; simultaneous push and pop keep occupancy.
module fpu_issue_fifo
   import fpu_issue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst_l,
   input  logic               push_i,
   input  logic [INSTR_W-1:0] push_dat_i,
   input  logic               pop_i,
   output logic [INSTR_W-1:0] head_dat_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [AW:0]        wr_ptr_q, wr_ptr_d;
   logic [AW:0]        rd_ptr_q, rd_ptr_d;
   logic               do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
   assign rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
      end
   end

   assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fpu_issue_seq.sv
// Buffers host instructions and issues them to the decoder: 3 cycles per INT/CSR, FP held until fpu_complete.
// host_ready drops only when the buffer is full; HALT stops issue but keeps buffered words.
module fpu_issue_seq
   import fpu_issue_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int FP_TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_l,
   fpu_issue_seq_if.slave bus
);

   localparam int TW = (FP_TIMEOUT < 2) ? 1 : $clog2(FP_TIMEOUT);
   localparam logic [TW-1:0]    WAIT_LAST = TW'(FP_TIMEOUT - 1);
   localparam logic [TW-1:0]    WAIT_ONE  = TW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] cur_q, cur_d;
   iclass_e            cls_q, cls_d;
   logic [TW-1:0]      wait_q, wait_d;
   logic [CNT_W-1:0]   issued_q, issued_d;
   logic               err_to_q, err_to_d;
   logic               err_il_q, err_il_d;

   logic [INSTR_W-1:0] head_dat;
   logic               fifo_full, fifo_empty;
   logic               pop;
   iclass_e            head_cls;
   logic               can_issue;

   logic [INSTR_W-1:0] instr_out;
   logic               act_out;
   logic               fpu_act_out;

   fpu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_l      (rst_l),
      .push_i     (bus.host_valid),
      .push_dat_i (bus.host_instr),
      .pop_i      (pop),
      .head_dat_o (head_dat),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   assign head_cls  = decode_class(head_dat[6:0]);
   assign can_issue = bus.start && !fifo_empty;

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         cur_q    <= '0;
         cls_q    <= CLS_INT;
         wait_q   <= '0;
         issued_q <= '0;
         err_to_q <= 1'b0;
         err_il_q <= 1'b0;
      end else begin
         cur_q    <= cur_d;
         cls_q    <= cls_d;
         wait_q   <= wait_d;
         issued_q <= issued_d;
         err_to_q <= err_to_d;
         err_il_q <= err_il_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      cls_d    = cls_q;
      wait_d   = wait_q;
      issued_d = issued_q;
      err_to_d = err_to_q;
      err_il_d = err_il_q | (bus.illegal_config & fpu_act_out);
      case (state_q)
         ST_IDLE: begin
            if (can_issue) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            cur_d  = head_dat;
            cls_d  = head_cls;
            wait_d = '0;
            if (bus.halt_req)          state_d = ST_HALT;
            else if (head_cls == CLS_FP) state_d = ST_FP_WAIT;
            else                       state_d = ST_WB1;
         end
         ST_WB1: begin
            state_d = bus.halt_req ? ST_HALT : ST_WB2;
         end
         ST_WB2: begin
            // FP words already retired on fpu_complete; only INT/CSR retire here.
            if (bus.halt_req) begin
               state_d = ST_HALT;
            end else begin
               if (cls_q != CLS_FP) issued_d = issued_q + CNT_ONE;
               state_d = can_issue ? ST_ISSUE : ST_IDLE;
            end
         end
         ST_FP_WAIT: begin
            if (bus.halt_req) begin
               state_d = ST_HALT;
            end else if (bus.fpu_complete) begin
               issued_d = issued_q + CNT_ONE;
               state_d  = ST_WB1;
            end else if (wait_q == WAIT_LAST) begin
               err_to_d = 1'b1;
               state_d  = ST_HALT;
            end else begin
               wait_d = wait_q + WAIT_ONE;
            end
         end
         ST_HALT: begin
            if (bus.resume) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      instr_out   = '0;
      act_out     = 1'b0;
      fpu_act_out = 1'b0;
      pop         = 1'b0;
      case (state_q)
         ST_ISSUE: begin
            instr_out   = head_dat;
            pop         = 1'b1;
            fpu_act_out = (head_cls == CLS_FP);
         end
         ST_WB2: begin
            act_out = (cls_q == CLS_INT);
         end
         ST_FP_WAIT: begin
            instr_out   = cur_q;
            fpu_act_out = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.Instruction       = instr_out;
   assign bus.Activation_Signal = act_out;
   assign bus.fpu_active        = fpu_act_out;
   assign bus.host_ready        = !fifo_full;
   assign bus.busy              = (state_q != ST_IDLE) || !fifo_empty;
   assign bus.halted            = (state_q == ST_HALT);
   assign bus.err_timeout       = err_to_q;
   assign bus.err_illegal       = err_il_q;
   assign bus.issued_count      = issued_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed bench for fpu_issue_seq: lifecycle model of each instruction checked every cycle, plus literal checks.
module tb_fpu_issue_seq;

   localparam int DEPTH = 8;
   localparam int TMO   = 255;

   localparam logic [31:0] W_ADDI  = 32'h00700293;
   localparam logic [31:0] W_FADD  = 32'h0020F0D3;
   localparam logic [31:0] W_FMADD = 32'h1820F043;
   localparam logic [31:0] W_CSR   = 32'h30002573;

   logic clk   = 1'b0;
   logic rst_l = 1'b0;
   always #5 clk = ~clk;

   fpu_issue_seq_if bus ();
   fpu_issue_seq_if bus4 ();

   fpu_issue_seq #(.DEPTH(DEPTH), .FP_TIMEOUT(TMO)) dut  (.clk(clk), .rst_l(rst_l), .bus(bus));
   fpu_issue_seq #(.DEPTH(DEPTH), .FP_TIMEOUT(4))   dut4 (.clk(clk), .rst_l(rst_l), .bus(bus4));

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- behavioural model: one instruction's lifetime counted in cycles since issue
   logic [31:0] mq[$];
   bit          m_halted = 0, m_live = 0, m_eto = 0, m_eil = 0;
   int          m_age = 0, m_end = 0, m_cls = 0;
   logic [31:0] m_word = '0;
   logic [15:0] m_ret = '0;
   bit          push_ok, was_issue, fpa;

   function automatic int cls_of(input logic [31:0] w);
      logic [6:0] op;
      op = w[6:0];
      if (op == 7'h53 || op == 7'h43 || op == 7'h47 || op == 7'h4B || op == 7'h4F) return 2;
      if (op == 7'h73) return 1;
      return 0;
   endfunction

   function bit m_show();
      return m_live && (m_age == 0 || (m_cls == 2 && m_end < 0));
   endfunction

   task m_try_start();
      if (bus.start && mq.size() > 0) begin
         m_live = 1;
         m_age  = 0;
         m_word = mq[0];
         m_cls  = cls_of(mq[0]);
         m_end  = (m_cls == 2) ? -1 : 0;
      end
   endtask

   always @(posedge clk) begin
      if (!rst_l) begin
         mq.delete();
         m_halted = 0; m_live = 0; m_eto = 0; m_eil = 0; m_ret = '0; m_age = 0;
      end else begin
         push_ok   = bus.host_valid && mq.size() < DEPTH;
         was_issue = m_live && m_age == 0;
         fpa       = m_show() && m_cls == 2;
         if (bus.illegal_config && fpa) m_eil = 1;
         if (m_halted) begin
            if (bus.resume) m_halted = 0;
         end else if (m_live) begin
            if (bus.halt_req) begin
               m_live = 0; m_halted = 1;
            end else if (m_cls == 2 && m_end < 0 && m_age >= 1 && bus.fpu_complete) begin
               m_end = m_age; m_ret++; m_age++;
            end else if (m_cls == 2 && m_end < 0 && m_age == TMO) begin
               m_eto = 1; m_live = 0; m_halted = 1;
            end else if (m_end >= 0 && m_age == m_end + 2) begin
               if (m_cls != 2) m_ret++;
               m_live = 0;
               m_try_start();
            end else begin
               m_age++;
            end
         end else begin
            m_try_start();
         end
         if (was_issue) void'(mq.pop_front());
         if (push_ok) mq.push_back(bus.host_instr);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_instr",  bus.Instruction, m_show() ? m_word : 32'h0);
         chk("m_strobe", 32'(bus.Activation_Signal), 32'(m_live && m_cls == 0 && m_age == 2));
         chk("m_fpu_active", 32'(bus.fpu_active), 32'(m_show() && m_cls == 2));
         chk("m_host_ready", 32'(bus.host_ready), 32'(mq.size() < DEPTH));
         chk("m_busy",   32'(bus.busy), 32'(m_live || m_halted || mq.size() != 0));
         chk("m_halted", 32'(bus.halted), 32'(m_halted));
         chk("m_err_timeout", 32'(bus.err_timeout), 32'(m_eto));
         chk("m_err_illegal", 32'(bus.err_illegal), 32'(m_eil));
         chk("m_issued", 32'(bus.issued_count), 32'(m_ret));
      end
   end

   // ---------------- directed stimulus
   logic [31:0] ins [16];
   logic        stb [16];
   logic        fac [16];
   logic        hlt [16];
   logic        eto [16];

   task push_word(input logic [31:0] w);
      bus.host_valid = 1'b1;
      bus.host_instr = w;
      tick();
      bus.host_valid = 1'b0;
   endtask

   initial begin
      int first, n_act, n_stb, n_stable, base;
      bus.host_valid = 0; bus.host_instr = '0; bus.start = 0; bus.resume = 0;
      bus.fpu_complete = 0; bus.halt_req = 0; bus.illegal_config = 0;
      bus4.host_valid = 0; bus4.host_instr = '0; bus4.start = 0; bus4.resume = 0;
      bus4.fpu_complete = 0; bus4.halt_req = 0; bus4.illegal_config = 0;

      tick();
      cmp_en = 1'b1;
      tick();
      chk("rst_instr", bus.Instruction, 32'h0);
      chk("rst_host_ready", 32'(bus.host_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_issued", 32'(bus.issued_count), 32'd0);
      rst_l = 1'b1;

      // ADDI: word shown in cycle N, strobe only at N+2; illegal_config ignored when no FP is active
      push_word(W_ADDI);
      bus.start = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         ins[c] = bus.Instruction; stb[c] = bus.Activation_Signal;
         bus.illegal_config = (c == 0);
      end
      bus.illegal_config = 0;
      bus.start = 1'b0;
      first = 13; n_stb = 0;
      for (int c = 7; c >= 0; c--) begin
         if (ins[c] == W_ADDI) first = c;
         if (stb[c]) n_stb++;
      end
      chk("041_seen_at_first_issue", first, 0);
      chk("041_bubble_after_issue", ins[first + 1], 32'h0);
      chk("041_strobe_at_N+2", 32'(stb[first + 2]), 32'd1);
      chk("041_strobe_count", n_stb, 1);
      chk("041_issued", 32'(bus.issued_count), 32'd1);
      chk("041_no_illegal", 32'(bus.err_illegal), 32'd0);

      // FADD: complete sampled in the 5th FP_WAIT cycle
      push_word(W_FADD);
      bus.start = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         ins[c] = bus.Instruction; stb[c] = bus.Activation_Signal; fac[c] = bus.fpu_active;
         bus.fpu_complete   = (c == 5);
         bus.illegal_config = (c == 2);
      end
      bus.start = 1'b0;
      n_act = 0; n_stb = 0; n_stable = 0;
      for (int c = 0; c < 12; c++) begin
         if (fac[c]) n_act++;
         if (stb[c]) n_stb++;
         if (c <= 5 && fac[c] && ins[c] == W_FADD) n_stable++;
      end
      chk("042_active_cycles", n_act, 6);
      chk("042_instr_stable", n_stable, 6);
      chk("042_bubble1", ins[6], 32'h0);
      chk("042_bubble2", ins[7], 32'h0);
      chk("042_no_strobe", n_stb, 0);
      chk("042_issued", 32'(bus.issued_count), 32'd2);
      chk("032_err_illegal", 32'(bus.err_illegal), 32'd1);

      // FP timeout with FP_TIMEOUT=4 on the second instance
      bus4.host_valid = 1'b1; bus4.host_instr = W_FADD;
      tick();
      bus4.host_valid = 1'b0; bus4.start = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         hlt[c] = bus4.halted; eto[c] = bus4.err_timeout; fac[c] = bus4.fpu_active;
      end
      chk("043_no_err_in_4th_wait", 32'(eto[4]), 32'd0);
      chk("043_active_in_4th_wait", 32'(fac[4]), 32'd1);
      chk("043_err_timeout", 32'(eto[5]), 32'd1);
      chk("043_halted", 32'(hlt[5]), 32'd1);
      chk("043_active_dropped", 32'(fac[5]), 32'd0);
      chk("043_no_retire", 32'(bus4.issued_count), 32'd0);
      bus4.start = 1'b0; bus4.resume = 1'b1;
      tick();
      bus4.resume = 1'b0;
      chk("043_resume_idle", 32'(bus4.halted), 32'd0);
      chk("043_resume_not_busy", 32'(bus4.busy), 32'd0);

      // Default timeout on the main instance
      push_word(W_FADD);
      bus.start = 1'b1;
      repeat (262) tick();
      bus.start = 1'b0;
      chk("tmo255_halted", 32'(bus.halted), 32'd1);
      chk("tmo255_err", 32'(bus.err_timeout), 32'd1);
      bus.resume = 1'b1;
      tick();
      bus.resume = 1'b0;
      chk("tmo255_resume", 32'(bus.halted), 32'd0);

      // Fill to full with start low; the ninth push is dropped
      for (int i = 0; i < 9; i++) begin
         push_word(32'h00000013 | (32'(i + 1) << 20));
         if (i == 6) chk("044_ready_at_7", 32'(bus.host_ready), 32'd1);
         if (i == 7) chk("044_full_after_8", 32'(bus.host_ready), 32'd0);
      end
      base = int'(bus.issued_count);
      bus.start = 1'b1;
      repeat (30) tick();
      bus.start = 1'b0;
      chk("044_retired_8", int'(bus.issued_count) - base, 8);
      chk("044_drained", 32'(bus.busy), 32'd0);

      // Push in the same cycle as a pop; CSR word gives no strobe
      push_word(W_ADDI);
      bus.start = 1'b1;
      tick();
      push_word(W_CSR);
      base = int'(bus.issued_count);
      repeat (10) tick();
      bus.start = 1'b0;
      chk("033_both_retired", int'(bus.issued_count) - base, 2);

      // halt_req together with fpu_complete in FP_WAIT
      push_word(W_FMADD);
      bus.start = 1'b1;
      repeat (4) tick();
      base = int'(bus.issued_count);
      bus.halt_req = 1'b1; bus.fpu_complete = 1'b1;
      tick();
      bus.halt_req = 1'b0; bus.fpu_complete = 1'b0;
      chk("045_halted", 32'(bus.halted), 32'd1);
      chk("045_no_retire", int'(bus.issued_count), base);
      chk("045_active_low", 32'(bus.fpu_active), 32'd0);
      push_word(W_ADDI);
      repeat (2) tick();
      chk("031_no_issue_in_halt", bus.Instruction, 32'h0);
      bus.start = 1'b0; bus.resume = 1'b1;
      tick();
      bus.resume = 1'b0;
      chk("031_buffer_kept", 32'(bus.busy), 32'd1);
      bus.halt_req = 1'b1;
      tick();
      bus.halt_req = 1'b0;
      chk("030_idle_ignores_halt", 32'(bus.halted), 32'd0);
      bus.start = 1'b1;
      repeat (6) tick();
      bus.start = 1'b0;
      chk("031_kept_word_retired", int'(bus.issued_count), base + 1);

      // Reset during FP_WAIT
      push_word(W_FADD);
      push_word(W_ADDI);
      bus.start = 1'b1;
      repeat (3) tick();
      chk("046_in_fp_wait", 32'(bus.fpu_active), 32'd1);
      rst_l = 1'b0;
      tick();
      rst_l = 1'b1; bus.start = 1'b0;
      chk("046_instr", bus.Instruction, 32'h0);
      chk("046_fpu_active", 32'(bus.fpu_active), 32'd0);
      chk("046_strobe", 32'(bus.Activation_Signal), 32'd0);
      chk("046_host_ready", 32'(bus.host_ready), 32'd1);
      chk("046_busy", 32'(bus.busy), 32'd0);
      chk("046_halted", 32'(bus.halted), 32'd0);
      chk("046_issued", 32'(bus.issued_count), 32'd0);
      chk("046_err_timeout", 32'(bus.err_timeout), 32'd0);
      chk("046_err_illegal", 32'(bus.err_illegal), 32'd0);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
